// File: rtl/arith_pkg.sv
// Shared arithmetic definitions for the multiplier and divider sequencers.
package arith_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } seq_state_t;

    localparam int unsigned DEFAULT_WORD_WIDTH = 8;

endpackage

// File: rtl/multiplier_booth_signed.sv
// Sequential radix-2 Booth signed multiply-accumulate: PRODUCT = A*B + C,
// one Booth step per enabled RUN cycle, start/done handshake with CE gating.
module multiplier_booth_signed
    import arith_pkg::*;
#(
    parameter int unsigned WORD_WIDTH = DEFAULT_WORD_WIDTH
) (
    input  logic                      CLK,
    input  logic                      ARST,
    input  logic                      CE,
    input  logic                      start,
    input  logic [WORD_WIDTH-1:0]     MULTIPLICAND_IN,
    input  logic [WORD_WIDTH-1:0]     MULTIPLIER_IN,
    input  logic [WORD_WIDTH-1:0]     ADDEND_IN,
    output logic [2*WORD_WIDTH-1:0]   PRODUCT_OUT,
    output logic                      busy,
    output logic                      done
);

    localparam int unsigned CW = $clog2(WORD_WIDTH + 1);
    localparam logic [CW-1:0] LAST_STEP = CW'(WORD_WIDTH - 1);

    seq_state_t            state;
    logic [CW-1:0]         cnt;
    logic [WORD_WIDTH:0]   upper;
    logic [WORD_WIDTH-1:0] mreg;
    logic                  q_1;
    logic [WORD_WIDTH-1:0] mcand;
    logic [WORD_WIDTH-1:0] addend;

    logic [WORD_WIDTH:0]     mcand_ext;
    logic [WORD_WIDTH:0]     sum;
    logic [WORD_WIDTH:0]     upper_nxt;
    logic [WORD_WIDTH-1:0]   mreg_nxt;
    logic                    q1_nxt;
    logic [2*WORD_WIDTH-1:0] result_nxt;

    // Booth add/subtract on the (W+1)-bit upper half, then arithmetic shift right
    // of {upper, mreg, q_1}. The addend is folded in on the final step instead of
    // being pre-scaled into the accumulator, keeping the upper adder free of
    // the extra headroom C would need.
    always_comb begin
        mcand_ext = {mcand[WORD_WIDTH-1], mcand};
        sum       = upper;
        unique case ({mreg[0], q_1})
            2'b01:   sum = upper + mcand_ext;
            2'b10:   sum = upper - mcand_ext;
            default: sum = upper;
        endcase
        upper_nxt  = {sum[WORD_WIDTH], sum[WORD_WIDTH:1]};
        mreg_nxt   = {sum[0], mreg[WORD_WIDTH-1:1]};
        q1_nxt     = mreg[0];
        result_nxt = {upper_nxt[WORD_WIDTH-1:0], mreg_nxt}
                   + {{WORD_WIDTH{addend[WORD_WIDTH-1]}}, addend};
    end

    // Sequencer: operand load on accepted start, Booth steps in RUN, registered
    // busy/done/product; CE low freezes everything.
    always_ff @(posedge CLK or posedge ARST) begin
        if (ARST) begin
            state       <= IDLE;
            cnt         <= '0;
            upper       <= '0;
            mreg        <= '0;
            q_1         <= 1'b0;
            mcand       <= '0;
            addend      <= '0;
            PRODUCT_OUT <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else if (CE) begin
            unique case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        upper  <= '0;
                        mreg   <= MULTIPLIER_IN;
                        q_1    <= 1'b0;
                        mcand  <= MULTIPLICAND_IN;
                        addend <= ADDEND_IN;
                        cnt    <= '0;
                        busy   <= 1'b1;
                        state  <= RUN;
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                RUN: begin
                    upper <= upper_nxt;
                    mreg  <= mreg_nxt;
                    q_1   <= q1_nxt;
                    cnt   <= cnt + 1'b1;
                    if (cnt == LAST_STEP) begin
                        PRODUCT_OUT <= result_nxt;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                        state       <= DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multiplier_booth_signed.sv
// Self-checking bench for multiplier_booth_signed: fixed vector table, random
// MAC vectors against plain integer arithmetic, handshake corner sequences and
// a divider-style reconstruction sweep.
module tb_multiplier_booth_signed;

    localparam int W = 8;

    logic                  tb_clk = 1'b0;
    logic                  tb_srst;
    logic                  ce;
    logic                  start;
    logic signed [W-1:0]   a_in;
    logic signed [W-1:0]   b_in;
    logic signed [W-1:0]   c_in;
    logic signed [2*W-1:0] product;
    logic                  busy;
    logic                  done;

    int n_vec  = 0;
    int n_fail = 0;

    typedef struct {
        int a;
        int b;
        int c;
        int exp;
    } vec_t;

    vec_t table_v[5];

    always #5 tb_clk = ~tb_clk;

    multiplier_booth_signed #(.WORD_WIDTH(W)) dut (
        .CLK             (tb_clk),
        .ARST            (tb_srst),
        .CE              (ce),
        .start           (start),
        .MULTIPLICAND_IN (a_in),
        .MULTIPLIER_IN   (b_in),
        .ADDEND_IN       (c_in),
        .PRODUCT_OUT     (product),
        .busy            (busy),
        .done            (done)
    );

    function automatic int ref_mac(input int a, input int b, input int c);
        return a * b + c;
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic set_ops(input int a, input int b, input int c);
        a_in = W'(a);
        b_in = W'(b);
        c_in = W'(c);
    endtask

    // Present operands with start for one edge; returns just after the accepting edge.
    task automatic launch(input int a, input int b, input int c);
        @(negedge tb_clk);
        set_ops(a, b, c);
        start = 1'b1;
        @(negedge tb_clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!done && lat < 40) begin
            @(negedge tb_clk);
            lat++;
        end
    endtask

    task automatic run_job(input string name, input int a, input int b, input int c, input int exp);
        int lat;
        launch(a, b, c);
        check({name, "_busy"}, longint'(busy), 1);
        wait_done(lat);
        check({name, "_lat"}, lat, W);
        check({name, "_prod"}, longint'(product), exp);
        @(negedge tb_clk);
        check({name, "_done_pulse"}, longint'(done), 0);
    endtask

    initial begin
        int lat;
        int lat2;
        int seen;
        int a;
        int b;
        int c;
        int num;
        int den;

        table_v[0] = '{a: -128, b: -128, c:    0, exp:  16384};
        table_v[1] = '{a:  127, b: -128, c: -128, exp: -16384};
        table_v[2] = '{a:   13, b:   -7, c:    5, exp:    -86};
        table_v[3] = '{a:    0, b: -128, c:   -1, exp:     -1};
        table_v[4] = '{a:   -1, b:   -1, c:  127, exp:    128};

        tb_srst = 1'b1;
        ce      = 1'b1;
        start   = 1'b0;
        set_ops(0, 0, 0);
        repeat (2) @(negedge tb_clk);
        check("rst_prod", longint'(product), 0);
        check("rst_busy", longint'(busy), 0);
        check("rst_done", longint'(done), 0);
        tb_srst = 1'b0;
        repeat (2) @(negedge tb_clk);
        check("idle_prod", longint'(product), 0);
        check("idle_busy", longint'(busy), 0);
        check("idle_done", longint'(done), 0);

        for (int i = 0; i < 5; i++) begin
            run_job($sformatf("table%0d", i), table_v[i].a, table_v[i].b, table_v[i].c, table_v[i].exp);
        end

        for (int i = 0; i < 150; i++) begin
            a = int'($urandom_range(0, 255)) - 128;
            b = int'($urandom_range(0, 255)) - 128;
            c = int'($urandom_range(0, 255)) - 128;
            run_job($sformatf("rand%0d", i), a, b, c, ref_mac(a, b, c));
        end

        // Async abort mid-run: product must drop from its last value to zero.
        launch(13, -7, 5);
        repeat (3) @(negedge tb_clk);
        #2 tb_srst = 1'b1;
        #1;
        check("abort_busy", longint'(busy), 0);
        check("abort_done", longint'(done), 0);
        check("abort_prod", longint'(product), 0);
        @(negedge tb_clk);
        tb_srst = 1'b0;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge tb_clk);
            if (busy || done) seen = 1;
        end
        check("abort_no_activity", seen, 0);
        check("abort_prod_held", longint'(product), 0);

        // CE low for three cycles inside RUN.
        launch(13, -7, 5);
        lat = 0;
        while (!done && lat < 40) begin
            @(negedge tb_clk);
            lat++;
            if (lat == 3) ce = 1'b0;
            if (lat == 6) ce = 1'b1;
        end
        check("ce_run_lat", lat, 11);
        check("ce_run_prod", longint'(product), -86);
        @(negedge tb_clk);
        check("ce_run_done_pulse", longint'(done), 0);

        // CE low while in DONE keeps done asserted.
        launch(-3, 9, 4);
        wait_done(lat);
        check("ce_done_lat", lat, W);
        ce = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge tb_clk);
            check("ce_done_hold", longint'(done), 1);
            check("ce_done_prod", longint'(product), -23);
        end
        ce = 1'b1;
        @(negedge tb_clk);
        check("ce_done_release", longint'(done), 0);
        check("ce_done_idle", longint'(busy), 0);

        // start held through RUN with changing operands is ignored.
        launch(13, -7, 5);
        lat = 0;
        start = 1'b1;
        set_ops(int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128);
        while (lat < 40) begin
            @(negedge tb_clk);
            lat++;
            if (done) begin
                start = 1'b0;
                break;
            end
            set_ops(int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128);
        end
        start = 1'b0;
        check("runstart_lat", lat, W);
        check("runstart_prod", longint'(product), -86);
        @(negedge tb_clk);
        check("runstart_idle", longint'(busy), 0);

        // Back-to-back: start in the DONE cycle.
        launch(20, 30, -5);
        wait_done(lat);
        check("b2b_first_lat", lat, W);
        check("b2b_first_prod", longint'(product), 595);
        set_ops(-50, 3, 7);
        start = 1'b1;
        @(negedge tb_clk);
        start = 1'b0;
        check("b2b_busy", longint'(busy), 1);
        check("b2b_done_once", longint'(done), 0);
        check("b2b_prod_hold", longint'(product), 595);
        wait_done(lat2);
        check("b2b_second_lat", lat2 + 1, W + 1);
        check("b2b_second_prod", longint'(product), -143);

        // Rebuild num from divider-style quotient/remainder.
        for (int i = 0; i < 200; i++) begin
            num = int'($urandom_range(0, 255)) - 128;
            den = 0;
            while (den == 0 || (num == -128 && den == -1))
                den = int'($urandom_range(0, 255)) - 128;
            run_job($sformatf("div%0d_n%0d_d%0d", i, num, den), den, num / den, num % den, num);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
